instr_queue: RTL

//  Parametrised instruction register/queue for the multicycle CPU fetch path.
//  It generalises the single hold-register IR into a DEPTH-entry FIFO with a

---
 rtl/instr_queue.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/instr_queue.sv
// -----------------------------------------------------------------------------
// instr_queue
//
// Instruction queue for the multicycle CPU fetch path. It replaces the single
// hold-register IR with a DEPTH-entry FIFO. Instruction memory is the producer
// and the control/decode stage is the consumer. The consumer always sees the
// oldest buffered instruction at the head.
//
// Handshake: a transfer happens on a rising edge of i_clk when the offering
// side's valid and the accepting side's ready are both 1 at that edge.
//   - Push side: i_valid & o_ready.
//   - Pop side:  o_valid & i_ready.
// Valid does not depend on ready on either side. A word that is offered and
// not accepted can be re-offered later. i_flush overrides both transfers in
// its cycle.
//
// Parameters:
//   WIDTH  instruction word width in bits (default 32)
//   DEPTH  number of entries; power of 2, >= 2 (default 4)
//   CW     occupancy count width, $clog2(DEPTH)+1 (derived)
//
// Ports:
//   i_clk    in   1      clock; all state updates on the rising edge
//   i_rst    in   1      asynchronous reset, active-high
//   i_valid  in   1      producer offers i_Instr this cycle
//   i_Instr  in   WIDTH  instruction word from memory
//   o_ready  out  1      queue can accept a word (not full)
//   o_valid  out  1      head entry is valid (not empty)
//   i_ready  in   1      consumer takes the head this cycle
//   o_Instr  out  WIDTH  head instruction; 0 when the queue is empty
//   i_flush  in   1      discard all buffered entries
//   o_count  out  CW     current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module instr_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_Instr,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_Instr,
  input  logic             i_flush,
  output logic [CW-1:0]    o_count
);

  // Address width of the storage array. Pointers carry one extra MSB so that
  // "full" and "empty" are told apart by the pointer difference alone.
  localparam int AW = CW - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Elaboration-time guard: the wrap-around pointer scheme needs a power of 2.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("instr_queue: DEPTH must be a power of 2 and at least 2");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // ---------------------------------------------------------------------------
  // Status derived from the registered pointers only
  // ---------------------------------------------------------------------------
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  // Modulo-2^CW subtraction gives the occupancy across pointer wrap.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // ---------------------------------------------------------------------------
  // Transfer qualification
  // ---------------------------------------------------------------------------
  // i_valid and i_ready are ANDed with known status bits, and those status
  // bits come only from registered state. An X on an idle handshake input
  // therefore cannot reach the pointers unless the matching side is able to
  // transfer. A flush drops any transfer offered in the same cycle.
  logic push;
  logic pop;

  assign push = i_valid & ~full  & ~i_flush;
  assign pop  = i_ready & ~empty & ~i_flush;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (i_flush) begin
      // Collapse the read pointer onto the write pointer. The stored words
      // stay in the array but are no longer reachable.
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + CW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + CW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = i_Instr;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Reset clears only the pointers. That alone empties the queue and forces
  // o_Instr to 0, so the storage array is left without a reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The head comes straight from registered storage and pointers. There is no
  // bypass from i_Instr, so a word pushed into an empty queue first appears in
  // the cycle after its push edge. The head is gated to 0 when the queue is
  // empty, so stale storage never shows.
  assign o_ready = ~full;
  assign o_valid = ~empty;
  assign o_count = count;
  assign o_Instr = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule
